sync_event_counter_mc: RTL and testbench
========================================

// Module: sync_event_counter_mc
// PURPOSE
// - Multi-channel gated event (frequency) counter: counts rising edges on NUM_CH async inputs over a fixed gate window of GATE_CYCLES clk cycles.
// - Snapshots all channels at window end, then raises data_ready for the MicroBlaze GPIO reader; valid/ack handshake with overrun detection.
// - Continuous back-to-back windows with no dead time. Sits between board I/O pins and the processor GPIO block.
// PARAMETERS
// - NUM_CH       4            number of event channels (1..16)
// - CNT_WIDTH    32           width of per-channel counters and snapshots
// - GATE_CYCLES  100_000_000  gate window length in clk cycles (1 s at 100 MHz); >= 2
// - SYNC_STAGES  2            synchroniser flops per input (>= 2)
// - localparam SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
// PORTS
// - clk             in   1          system clock
// - reset           in   1          asynchronous, active-high reset
// - enable          in   1          run counting; 0 = idle
// - event_trigger   in   NUM_CH     async event inputs, one bit per channel
// - ch_sel          in   SEL_W      channel select for events_counted readback
// - data_ack        in   1          reader acknowledges current snapshot
// - events_counted  out  CNT_WIDTH  snapshot of channel ch_sel (combinational mux)
// - saturated       out  1          snapshot of channel ch_sel hit all-ones
// - data_ready      out  1          snapshot valid, held until data_ack
// - overrun         out  1          sticky: snapshot overwritten before ack
// BEHAVIOUR
// - Reset (async): state=IDLE, cycle/running counters, snapshots, sat bits, sync/edge regs = 0; data_ready=0, overrun=0.
// - Input path per channel: SYNC_STAGES flops, then edge reg; pulse = sync & ~prev. Pin edge to increment latency = SYNC_STAGES+1 cycles.
// - FSM states:
//   IDLE:  counters held at 0. enable=1 -> ARM.
//   ARM:   lasts SYNC_STAGES+1 cycles, pulses ignored (flushes stale sync data), cycle counter 0 -> COUNT.
//   COUNT: cycle counter 0..GATE_CYCLES-1; running[ch] += pulse[ch] each cycle.
//     At cycle GATE_CYCLES-1: snapshot[ch] <= running[ch]+pulse[ch] (saturating), sat[ch] latched,
//     running <= 0, cycle counter <= 0, stay in COUNT. Window = exactly GATE_CYCLES cycles, no dead time.
//   enable=0 in ARM/COUNT -> IDLE next cycle; partial window discarded; snapshots, data_ready, overrun retained.
// - Arithmetic: running counters saturate at 2^CNT_WIDTH-1 (no wrap); sat[ch] set if saturation reached in that window.
// - Handshake: snapshot event sets data_ready=1 next cycle. data_ack while data_ready=1 clears it.
//   data_ack while data_ready=0 ignored.
//   Snapshot while data_ready=1 and no data_ack that cycle: data overwritten, overrun<=1 (sticky until reset).
//   Snapshot and data_ack same cycle: data_ready stays 1, overrun unchanged.
// - ch_sel >= NUM_CH: events_counted=0, saturated=0.
// - Simultaneous events on all channels counted independently in the same cycle.
// CONFIGURATION
// - SYNC_EVT_CNT_DUAL_EDGE_EN defined: pulse = sync ^ prev (both edges counted; a square wave yields 2x frequency).
// - Undefined: rising edges only (default). No port or parameter change either way.
// TESTING (bench: NUM_CH=2, CNT_WIDTH=8, GATE_CYCLES=100, SYNC_STAGES=2)
// - 1: ch0 square wave period 10 clk, ch1 tied 0, enable=1 -> per window ch0 snapshot=10 (20 with DUAL_EDGE_EN), ch1=0, data_ready pulses once per 100 cycles.
// - 2: ch1 toggled every clk (50 rising edges/window) with CNT_WIDTH=4 -> snapshot=15, saturated=1; next window with no edges -> 0, saturated=0.
// - 3: never assert data_ack across two windows -> overrun=1 at second snapshot, events_counted shows second window value; ack+snapshot same cycle -> overrun stays 0.
// - 4: drop enable at cycle 50 of a window with 5 edges counted -> IDLE, no snapshot, data_ready unchanged; re-enable -> ARM 3 cycles then fresh full 100-cycle window.
// - 5: assert reset asynchronously mid-window (between clk edges) -> all outputs 0 immediately, no data_ready until a full window after re-enable.
// - 6: ch_sel=2 (out of range, NUM_CH=2) -> events_counted=0, saturated=0; edge at cycle 99 counts in the closing window, edge at cycle 0 in the next.

Source files
------------

// File: rtl/sync_event_counter_mc.sv
// sync_event_counter_mc
// Multi-channel gated event counter. Rising edges on each asynchronous
// event input are counted over back-to-back gate windows of GATE_CYCLES
// clock cycles. At every window end all channels are snapshotted together
// and data_ready is raised for the GPIO reader, which clears it with data_ack.
// A snapshot that replaces unread data sets the sticky overrun flag.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   enable         1 = run back-to-back windows, 0 = idle (partial window dropped)
//   event_trigger  asynchronous event inputs, one bit per channel
//   ch_sel         channel whose snapshot appears on events_counted/saturated
//   data_ack       reader acknowledge for the current snapshot
//   events_counted snapshot of channel ch_sel (0 when ch_sel >= NUM_CH)
//   saturated      snapshot of channel ch_sel reached all-ones
//   data_ready     snapshot valid, held until data_ack
//   overrun        sticky: a snapshot was overwritten before it was acknowledged
//
// Build option: define SYNC_EVT_CNT_DUAL_EDGE_EN to count both edges of each
// input instead of rising edges only.
//
// state | meaning
// IDLE  | counters held at 0, waiting for enable
// ARM   | SYNC_STAGES+1 cycles flushing stale synchroniser contents
// COUNT | gate window running, snapshot on its last cycle
module sync_event_counter_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int GATE_CYCLES = 100_000_000,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    event_trigger,
    input  logic [SEL_W-1:0]     ch_sel,
    input  logic                 data_ack,
    output logic [CNT_WIDTH-1:0] events_counted,
    output logic                 saturated,
    output logic                 data_ready,
    output logic                 overrun
);

    // One cycle counter serves both the ARM flush and the gate window.
    localparam int CYC_MAX = (GATE_CYCLES > SYNC_STAGES + 1) ? GATE_CYCLES : SYNC_STAGES + 1;
    localparam int CYC_W   = $clog2(CYC_MAX);
    localparam logic [CYC_W-1:0] GATE_LAST = CYC_W'(GATE_CYCLES - 1);
    localparam logic [CYC_W-1:0] ARM_LAST  = CYC_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  win_end;
    logic [CYC_W-1:0]      cyc_cnt;
    logic [NUM_CH-1:0]     sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]     sync_prev;
    logic [NUM_CH-1:0]     pulse;
    logic [CNT_WIDTH-1:0]  running [NUM_CH];
    logic [CNT_WIDTH-1:0]  run_inc [NUM_CH];
    logic [CNT_WIDTH-1:0]  snap    [NUM_CH];
    logic [NUM_CH-1:0]     snap_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_prev <= '0;
        end else begin
            sync_q[0] <= event_trigger;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

`ifdef SYNC_EVT_CNT_DUAL_EDGE_EN
    assign pulse = sync_q[SYNC_STAGES-1] ^ sync_prev;
`else
    assign pulse = sync_q[SYNC_STAGES-1] & ~sync_prev;
`endif

    // Saturating increment: an all-ones counter stays put.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            run_inc[c] = (&running[c]) ? running[c] : running[c] + CNT_WIDTH'(pulse[c]);
        end
    end

    always_comb begin
        state_nx = state;
        win_end  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = ARM;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (cyc_cnt == ARM_LAST) begin
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (cyc_cnt == GATE_LAST) begin
                    win_end = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            snap_sat   <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                running[c] <= '0;
                snap[c]    <= '0;
            end
        end else begin
            state <= state_nx;

            case (state)
                ARM: begin
                    cyc_cnt <= (cyc_cnt == ARM_LAST) ? '0 : cyc_cnt + CYC_W'(1);
                    for (int c = 0; c < NUM_CH; c++) begin
                        running[c] <= '0;
                    end
                end
                COUNT: begin
                    if (win_end) begin
                        // The pulse of the closing cycle belongs to this window.
                        cyc_cnt <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            snap[c]     <= run_inc[c];
                            snap_sat[c] <= &run_inc[c];
                            running[c]  <= '0;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                        for (int c = 0; c < NUM_CH; c++) begin
                            running[c] <= run_inc[c];
                        end
                    end
                end
                default: begin
                    cyc_cnt <= '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        running[c] <= '0;
                    end
                end
            endcase

            // A new snapshot keeps data_ready high even if acked in the same cycle.
            if (win_end) begin
                data_ready <= 1'b1;
                if (data_ready && !data_ack) begin
                    overrun <= 1'b1;
                end
            end else if (data_ack) begin
                data_ready <= 1'b0;
            end
        end
    end

    always_comb begin
        events_counted = '0;
        saturated      = 1'b0;
        if (32'(ch_sel) < NUM_CH) begin
            events_counted = snap[ch_sel];
            saturated      = snap_sat[ch_sel];
        end
    end

endmodule

// File: tb/tb_sync_event_counter_mc.sv
// Testbench for sync_event_counter_mc. Two instances share all inputs:
// dut (NUM_CH=2, CNT_WIDTH=8) and dut4 (NUM_CH=3, CNT_WIDTH=4, channel 2
// mirrors channel 0) so saturation and out-of-range readback are visible.
module tb_sync_event_counter_mc;

`ifdef SYNC_EVT_CNT_DUAL_EDGE_EN
    localparam int EM = 2;
`else
    localparam int EM = 1;
`endif

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] event_trigger;
    logic       ch_sel;
    logic [1:0] ch_sel4;
    logic       data_ack;
    logic [7:0] events_counted;
    logic       saturated;
    logic       data_ready;
    logic       overrun;
    logic [3:0] events_counted4;
    logic       saturated4;
    logic       data_ready4;
    logic       overrun4;

    int total = 0;
    int bad   = 0;
    int ph    = 0;
    bit sq_en  = 1'b0;
    bit tog_en = 1'b0;
    int q0 [$];
    int q1 [$];

    sync_event_counter_mc #(
        .NUM_CH(2), .CNT_WIDTH(8), .GATE_CYCLES(100), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .event_trigger(event_trigger),
        .ch_sel(ch_sel),
        .data_ack(data_ack),
        .events_counted(events_counted),
        .saturated(saturated),
        .data_ready(data_ready),
        .overrun(overrun)
    );

    sync_event_counter_mc #(
        .NUM_CH(3), .CNT_WIDTH(4), .GATE_CYCLES(100), .SYNC_STAGES(2)
    ) dut4 (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .event_trigger({event_trigger[0], event_trigger}),
        .ch_sel(ch_sel4),
        .data_ack(data_ack),
        .events_counted(events_counted4),
        .saturated(saturated4),
        .data_ready(data_ready4),
        .overrun(overrun4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat_val(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock; inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph == 9) ? 0 : ph + 1;
        if (sq_en) event_trigger[0] = (ph < 5);
        if (tog_en) event_trigger[1] = ~event_trigger[1];
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_ready(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!data_ready && n < 300) begin
            tick();
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("ack_clears", data_ready, 0);
    endtask

    task automatic push(input int v0, input int v1);
        q0.push_back(v0);
        q1.push_back(v1);
    endtask

    task automatic check_snap();
        int v0, v1, e;
        chk("sb_nonempty", q0.size() > 0, 1);
        if (q0.size() == 0) return;
        v0 = q0.pop_front();
        v1 = q1.pop_front();
        chk("rdy", data_ready, 1);
        chk("rdy4", data_ready4, 1);
        for (int i = 0; i < 4; i++) begin
            ch_sel  = i[0];
            ch_sel4 = 2'(i);
            #1;
            e = (i == 1) ? v1 : v0;
            if (i < 2) begin
                chk("cnt8", events_counted, sat_val(e, 255));
                chk("sat8", saturated, e >= 255);
            end
            if (i == 3) begin
                chk("cnt4_oor", events_counted4, 0);
                chk("sat4_oor", saturated4, 0);
            end else begin
                chk("cnt4", events_counted4, sat_val(e, 15));
                chk("sat4", saturated4, e >= 15);
            end
        end
        ch_sel  = 1'b0;
        ch_sel4 = 2'd0;
    endtask

    initial begin
        bit rose;
        reset = 1'b1;
        enable = 1'b0;
        event_trigger = 2'b00;
        ch_sel = 1'b0;
        ch_sel4 = 2'd0;
        data_ack = 1'b0;
        sq_en = 1'b1;
        ticks(3);
        chk("rst_rdy", data_ready, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", events_counted, 0);
        chk("rst_sat", saturated, 0);
        chk("rst_rdy4", data_ready4, 0);
        reset = 1'b0;
        tick();

        // square wave period 10 on ch0
        enable = 1'b1;
        push(10 * EM, 0);
        wait_ready("first_win_lat", 104);
        check_snap();
        ack();
        push(10 * EM, 0);
        wait_ready("win_period", 99);
        check_snap();

        // ch1 toggling every clock: saturates the 4-bit instance
        ack();
        sq_en = 1'b0;
        event_trigger[0] = 1'b0;
        tog_en = 1'b1;
        wait_ready("drain_a", 99);
        ack();
        push(0, 50 * EM);
        wait_ready("tog_period", 99);
        check_snap();
        ack();
        tog_en = 1'b0;
        wait_ready("drain_b", 99);
        ack();
        push(0, 0);
        wait_ready("quiet_period", 99);
        check_snap();

        // overrun: window with no ack, then one with three manual pulses
        ack();
        push(0, 0);
        wait_ready("ovr_first", 99);
        check_snap();
        chk("ovr_before", overrun, 0);
        push(3 * EM, 0);
        for (int i = 1; i <= 99; i++) begin
            tick();
            if (i == 20 || i == 30 || i == 40) event_trigger[0] = 1'b1;
            if (i == 25 || i == 35 || i == 45) event_trigger[0] = 1'b0;
        end
        chk("ovr_not_yet", overrun, 0);
        tick();
        chk("ovr_set", overrun, 1);
        chk("ovr_set4", overrun4, 1);
        check_snap();

        // asynchronous reset between clock edges
        #2;
        reset = 1'b1;
        enable = 1'b0;
        sq_en = 1'b1;
        #1;
        chk("arst_rdy", data_ready, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_cnt", events_counted, 0);
        chk("arst_sat4", saturated4, 0);
        chk("arst_ovr4", overrun4, 0);
        ticks(2);
        reset = 1'b0;
        tick();
        enable = 1'b1;
        push(10 * EM, 0);
        wait_ready("post_rst_lat", 104);
        check_snap();
        chk("post_rst_ovr", overrun, 0);

        // ack in the same cycle as the next snapshot
        push(10 * EM, 0);
        ticks(99);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("same_cyc_rdy", data_ready, 1);
        chk("same_cyc_ovr", overrun, 0);
        check_snap();

        // drop enable at cycle 50, then restart
        ack();
        ticks(49);
        enable = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (data_ready) rose = 1'b1;
        end
        chk("idle_no_rdy", rose, 0);
        chk("idle_keep_cnt", events_counted, sat_val(10 * EM, 255));
        chk("idle_keep_cnt4", events_counted4, sat_val(10 * EM, 15));
        enable = 1'b1;
        push(10 * EM, 0);
        wait_ready("reenable_lat", 104);
        check_snap();

        // window boundary: edge reaching cycle 99, then cycle 0
        ack();
        sq_en = 1'b0;
        event_trigger[0] = 1'b0;
        wait_ready("drain_c", 99);
        ack();
        ticks(96);
        event_trigger[0] = 1'b1;
        push(1, 0);
        wait_ready("edge99_lat", 3);
        check_snap();
        ack();
        ticks(49);
        event_trigger[0] = 1'b0;
        ticks(48);
        event_trigger[0] = 1'b1;
        push(EM - 1, 0);
        wait_ready("edge0_prev", 2);
        check_snap();
        ack();
        push(1, 0);
        wait_ready("edge0_next", 99);
        check_snap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
